// File: rtl/alu_sequencer.sv
// Control sequencer for the ALU/shifter/divider/HiLo datapath. Single-cycle ops
// return a result in the cycle after accept; DIVU runs the iterative divider, then commits to HiLo.
module alu_sequencer #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] Signal,
    input  logic       div_zero,
    output logic       div_start,
    output logic       hilo_we,
    output logic [5:0] mux_signal,
    output logic       out_valid,
    output logic       err
);

    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_MFHI = 6'b010000;
    localparam logic [5:0] OP_MFLO = 6'b010010;

    typedef enum logic [1:0] {IDLE, DIV, WB} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_start_q, div_start_d;
    logic             hilo_we_q, hilo_we_d;
    logic [5:0]       mux_q, mux_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic legal, is_divu, accept;

    always_comb begin
        legal = 1'b0;
        case (Signal)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_SRL, OP_DIVU, OP_MFHI, OP_MFLO: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    assign is_divu  = (Signal == OP_DIVU);
    assign in_ready = (state_q == IDLE) & reset;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_start_d = 1'b0;
        hilo_we_d   = 1'b0;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        mux_d       = mux_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        out_valid_d = 1'b1;
                        err_d       = 1'b1;
                        mux_d       = 6'b000000;
                    end else if (is_divu && div_zero) begin
                        // Divide-by-zero is reported at once; divider and HiLo are left untouched.
                        out_valid_d = 1'b1;
                        err_d       = 1'b1;
                        mux_d       = OP_DIVU;
                    end else if (is_divu) begin
                        state_d     = DIV;
                        cnt_d       = CNT_W'(DIV_CYCLES - 1);
                        div_start_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        mux_d       = Signal;
                    end
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    state_d   = WB;
                    hilo_we_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                mux_d       = OP_DIVU;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_start_q <= 1'b0;
            hilo_we_q   <= 1'b0;
            mux_q       <= 6'b000000;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_start_q <= div_start_d;
            hilo_we_q   <= hilo_we_d;
            mux_q       <= mux_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign div_start  = div_start_q;
    assign hilo_we    = hilo_we_q;
    assign mux_signal = mux_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: default 32-cycle divider plus a 1-cycle divider instance.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_valid1;
    logic [5:0] Signal;
    logic       div_zero;

    logic       in_ready, div_start, hilo_we, out_valid, err;
    logic [5:0] mux_signal;
    logic       in_ready1, div_start1, hilo_we1, out_valid1, err1;
    logic [5:0] mux_signal1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Signal(Signal), .div_zero(div_zero), .div_start(div_start),
        .hilo_we(hilo_we), .mux_signal(mux_signal), .out_valid(out_valid), .err(err)
    );

    alu_sequencer #(.DIV_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .Signal(Signal), .div_zero(div_zero), .div_start(div_start1),
        .hilo_we(hilo_we1), .mux_signal(mux_signal1), .out_valid(out_valid1), .err(err1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".in_ready"},  8'(in_ready),   8'd0);
        chk({tag, ".div_start"}, 8'(div_start),  8'd0);
        chk({tag, ".hilo_we"},   8'(hilo_we),    8'd0);
        chk({tag, ".out_valid"}, 8'(out_valid),  8'd0);
        chk({tag, ".err"},       8'(err),        8'd0);
        chk({tag, ".mux"},       8'(mux_signal), 8'h00);
    endtask

    logic [5:0] seq_codes [4];

    initial begin
        seq_codes[0] = 6'b100000; seq_codes[1] = 6'b100010;
        seq_codes[2] = 6'b101010; seq_codes[3] = 6'b000010;
        reset = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; Signal = 6'b0; div_zero = 1'b0;
        #3;
        chk_idle_reset("reset");

        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1 chk("release.in_ready", 8'(in_ready), 8'd1);

        // Four single-cycle ops back to back
        for (int i = 0; i < 4; i++) begin
            Signal = seq_codes[i]; in_valid = 1'b1;
            @(negedge clk);
            chk("seq.out_valid", 8'(out_valid),  8'd1);
            chk("seq.mux",       8'(mux_signal), 8'(seq_codes[i]));
            chk("seq.err",       8'(err),        8'd0);
            chk("seq.in_ready",  8'(in_ready),   8'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("seq.idle.out_valid", 8'(out_valid),  8'd0);
        chk("seq.hold.mux",       8'(mux_signal), 8'b000010);

        // DIVU with MFHI held behind it
        Signal = 6'b011011; div_zero = 1'b0; in_valid = 1'b1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            if (cyc == 1) Signal = 6'b010000;
            chk($sformatf("div.c%0d.div_start", cyc), 8'(div_start), 8'(cyc == 1));
            chk($sformatf("div.c%0d.hilo_we", cyc),   8'(hilo_we),   8'(cyc == 33));
            chk($sformatf("div.c%0d.in_ready", cyc),  8'(in_ready),  8'(cyc >= 34));
            chk($sformatf("div.c%0d.out_valid", cyc), 8'(out_valid), 8'(cyc == 34 || cyc == 35));
            if (cyc == 34) chk("div.result.mux", 8'(mux_signal), 8'b011011);
            if (cyc == 35) chk("mfhi.mux",       8'(mux_signal), 8'b010000);
            if (cyc == 34 || cyc == 35) chk($sformatf("div.c%0d.err", cyc), 8'(err), 8'd0);
            if (cyc == 35) in_valid = 1'b0;
        end

        // DIVU with divide-by-zero
        Signal = 6'b011011; div_zero = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; div_zero = 1'b0;
        chk("dz.out_valid", 8'(out_valid),  8'd1);
        chk("dz.err",       8'(err),        8'd1);
        chk("dz.mux",       8'(mux_signal), 8'b011011);
        chk("dz.div_start", 8'(div_start),  8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dz.after.div_start", 8'(div_start), 8'd0);
            chk("dz.after.hilo_we",   8'(hilo_we),   8'd0);
            chk("dz.after.out_valid", 8'(out_valid), 8'd0);
            chk("dz.after.in_ready",  8'(in_ready),  8'd1);
        end

        // Illegal code
        Signal = 6'b111111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill.out_valid", 8'(out_valid),  8'd1);
        chk("ill.err",       8'(err),        8'd1);
        chk("ill.mux",       8'(mux_signal), 8'h00);
        chk("ill.div_start", 8'(div_start),  8'd0);
        @(negedge clk);
        chk("ill.after.out_valid", 8'(out_valid),  8'd0);
        chk("ill.after.err",       8'(err),        8'd0);

        // Reset in cycle 10 of a divide
        Signal = 6'b011011; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort.div_start", 8'(div_start), 8'd1);
        for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
        chk("abort.c10.in_ready", 8'(in_ready), 8'd0);
        #2 reset = 1'b0;
        #1 chk_idle_reset("abort.async");
        @(negedge clk);
        reset = 1'b1;
        #1 chk("abort.release.in_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort.hilo_we",   8'(hilo_we),   8'd0);
            chk("abort.out_valid", 8'(out_valid), 8'd0);
        end

        // One-cycle divider: DIV for one cycle, WB, then result
        Signal = 6'b011011; div_zero = 1'b0; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("d1.c1.div_start", 8'(div_start1), 8'd1);
        chk("d1.c1.in_ready",  8'(in_ready1),  8'd0);
        chk("d1.c1.hilo_we",   8'(hilo_we1),   8'd0);
        @(negedge clk);
        chk("d1.c2.hilo_we",   8'(hilo_we1),   8'd1);
        chk("d1.c2.div_start", 8'(div_start1), 8'd0);
        chk("d1.c2.out_valid", 8'(out_valid1), 8'd0);
        @(negedge clk);
        chk("d1.c3.out_valid", 8'(out_valid1),  8'd1);
        chk("d1.c3.err",       8'(err1),        8'd0);
        chk("d1.c3.mux",       8'(mux_signal1), 8'b011011);
        chk("d1.c3.in_ready",  8'(in_ready1),   8'd1);
        chk("d1.c3.hilo_we",   8'(hilo_we1),    8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
